// File: rtl/vec_wb_pkg.sv
// Shared types and sizing for the vector writeback buffer.
package vec_wb_pkg;

  localparam int WB_VLEN = 512;
  localparam int WB_NB   = WB_VLEN / 8;
  localparam int WB_IW   = $clog2(WB_NB);

  // Element counts for a full register at each legal SEW.
  localparam int NE8  = WB_VLEN / 8;
  localparam int NE16 = WB_VLEN / 16;
  localparam int NE32 = WB_VLEN / 32;

  typedef enum logic [1:0] {
    SEW_8   = 2'b00,
    SEW_16  = 2'b01,
    SEW_32  = 2'b10,
    SEW_ILL = 2'b11
  } sew_e;

  typedef struct packed {
    logic [4:0]         addr;
    logic [WB_VLEN-1:0] data;
    logic [WB_NB-1:0]   byte_en;
  } wb_entry_t;

endpackage

// File: rtl/vec_wb_byte_en_gen.sv
// Byte-enable generation from SEW, vl and the v0 mask.
// An illegal SEW enables no bytes; vl is clamped to the element count.
module vec_wb_byte_en_gen
  import vec_wb_pkg::*;
#(
  parameter int VLW = $clog2(WB_NB) + 1
) (
  input  logic [1:0]       sew,
  input  logic [VLW-1:0]   vl,
  input  logic             vm,
  input  logic [WB_NB-1:0] v0_mask,
  output logic [WB_NB-1:0] byte_en
);

  int ne;
  int shift;
  int vl_eff;
  logic [WB_IW-1:0] eidx;

  // Map each byte to its element and enable it if the element is active.
  always_comb begin
    ne      = 0;
    shift   = 0;
    vl_eff  = 0;
    eidx    = '0;
    byte_en = '0;
    case (sew_e'(sew))
      SEW_8:   begin ne = NE8;  shift = 0; end
      SEW_16:  begin ne = NE16; shift = 1; end
      SEW_32:  begin ne = NE32; shift = 2; end
      default: begin ne = 0;    shift = 0; end
    endcase
    vl_eff = (int'(vl) > ne) ? ne : int'(vl);
    for (int b = 0; b < WB_NB; b++) begin
      eidx = WB_IW'(b >> shift);
      if ((int'(eidx) < vl_eff) && (vm || v0_mask[eidx])) begin
        byte_en[b] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_writeback_buffer.sv
// Vector writeback buffer: merges each result with old vd under tail/mask
// rules, queues it in a small FIFO and drains it to the register file.
// pending_vd flags destinations still queued so decode can stall.
module vec_writeback_buffer
  import vec_wb_pkg::*;
#(
  parameter int VLEN  = WB_VLEN,
  parameter int DEPTH = 2,
  parameter int VLW   = $clog2(VLEN/8) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VLEN-1:0]   exec_result,
  input  logic              exec_done,
  output logic              in_ready,
  input  logic [4:0]        vd_addr,
  input  logic [1:0]        sew,
  input  logic [VLW-1:0]    vl,
  input  logic              vm,
  input  logic [VLEN/8-1:0] v0_mask,
  input  logic [VLEN-1:0]   old_vd,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_addr,
  output logic [VLEN-1:0]   wb_data,
  output logic [VLEN/8-1:0] wb_byte_en,
  output logic [31:0]       pending_vd,
  output logic              overflow_err
);

  localparam int NB = VLEN / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [NB-1:0]    be_gen;
  logic [VLEN-1:0]  merged;
  wb_entry_t        new_entry;
  wb_entry_t        head;
  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] slot_vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;

  vec_wb_byte_en_gen #(.VLW(VLW)) u_be_gen (
    .sew     (sew),
    .vl      (vl),
    .vm      (vm),
    .v0_mask (v0_mask),
    .byte_en (be_gen)
  );

  // Byte-wise undisturbed merge ahead of the FIFO.
  always_comb begin
    merged = '0;
    for (int b = 0; b < NB; b++) begin
      merged[b*8 +: 8] = be_gen[b] ? exec_result[b*8 +: 8] : old_vd[b*8 +: 8];
    end
    new_entry.addr    = vd_addr;
    new_entry.data    = merged;
    new_entry.byte_en = be_gen;
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  // full is the pre-edge state, so a same-cycle dequeue never frees a slot
  assign enq      = exec_done && !full;
  assign deq      = !empty && wb_ready;

  // Entry storage; stale contents are hidden by the empty gating below.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr[AW-1:0]] <= new_entry;
    end
  end

  // Pointers, slot occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      slot_vld     <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr                     <= wr_ptr + PW'(1);
        slot_vld[wr_ptr[AW-1:0]]   <= 1'b1;
      end
      if (deq) begin
        rd_ptr                     <= rd_ptr + PW'(1);
        slot_vld[rd_ptr[AW-1:0]]   <= 1'b0;
      end
      if (exec_done && full) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Head outputs, forced to zero while the FIFO is empty.
  always_comb begin
    head       = mem[rd_ptr[AW-1:0]];
    wb_valid   = !empty;
    wb_addr    = empty ? '0 : head.addr;
    wb_data    = empty ? '0 : head.data;
    wb_byte_en = empty ? '0 : head.byte_en;
  end

  // Pending destinations: OR of one-hot vd over all occupied slots.
  always_comb begin
    pending_vd = '0;
    for (int s = 0; s < DEPTH; s++) begin
      if (slot_vld[s]) begin
        pending_vd[mem[s].addr] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vec_writeback_buffer.sv
// Scoreboard bench for vec_writeback_buffer with directed vectors.
module tb_vec_writeback_buffer;
  import vec_wb_pkg::*;

  localparam int VLEN = 512;
  localparam int NB   = VLEN / 8;
  localparam int VLW  = $clog2(NB) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [VLEN-1:0] exec_result;
  logic            exec_done;
  logic            in_ready;
  logic [4:0]      vd_addr;
  logic [1:0]      sew;
  logic [VLW-1:0]  vl;
  logic            vm;
  logic [NB-1:0]   v0_mask;
  logic [VLEN-1:0] old_vd;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_addr;
  logic [VLEN-1:0] wb_data;
  logic [NB-1:0]   wb_byte_en;
  logic [31:0]     pending_vd;
  logic            overflow_err;

  int n_checks = 0;
  int n_errors = 0;
  wb_entry_t exp_q[$];

  vec_writeback_buffer #(.VLEN(VLEN), .DEPTH(2), .VLW(VLW)) dut (
    .clk          (clk),
    .reset        (reset),
    .exec_result  (exec_result),
    .exec_done    (exec_done),
    .in_ready     (in_ready),
    .vd_addr      (vd_addr),
    .sew          (sew),
    .vl           (vl),
    .vm           (vm),
    .v0_mask      (v0_mask),
    .old_vd       (old_vd),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_byte_en   (wb_byte_en),
    .pending_vd   (pending_vd),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [VLEN-1:0] merge(input logic [VLEN-1:0] res, input logic [VLEN-1:0] old,
                                             input logic [NB-1:0] be);
    logic [VLEN-1:0] r;
    for (int b = 0; b < NB; b++) r[b*8 +: 8] = be[b] ? res[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string nm, input logic [4:0] vd, input logic [1:0] s,
                       input logic [VLW-1:0] l, input logic m, input logic [NB-1:0] v0,
                       input logic [VLEN-1:0] res, input logic [VLEN-1:0] old,
                       input logic [NB-1:0] exp_be, input bit exp_acc);
    wb_entry_t e;
    exec_done   = 1'b1;
    vd_addr     = vd;
    sew         = s;
    vl          = l;
    vm          = m;
    v0_mask     = v0;
    exec_result = res;
    old_vd      = old;
    check({nm, "_in_ready"}, VLEN'(in_ready), VLEN'(exp_acc));
    if (exp_acc) begin
      e.addr    = vd;
      e.data    = merge(res, old, exp_be);
      e.byte_en = exp_be;
      exp_q.push_back(e);
    end
    step();
    exec_done = 1'b0;
  endtask

  // Monitor: every accepted writeback is compared with the scoreboard head.
  initial begin
    wb_entry_t e;
    forever begin
      @(negedge clk);
      if (!reset && wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_wb: actual addr=%0d with empty scoreboard required none", wb_addr);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", VLEN'(wb_addr), VLEN'(e.addr));
          check("wb_data", wb_data, e.data);
          check("wb_byte_en", VLEN'(wb_byte_en), VLEN'(e.byte_en));
        end
      end
    end
  end

  localparam logic [VLEN-1:0] AA  = {64{8'hAA}};
  localparam logic [VLEN-1:0] X55 = {64{8'h55}};
  localparam logic [VLEN-1:0] DB  = {16{32'hDEADBEEF}};
  localparam logic [VLEN-1:0] OL  = {16{32'h01234567}};

  initial begin
    reset = 1'b1; exec_done = 1'b0; wb_ready = 1'b0; vd_addr = '0; sew = '0;
    vl = '0; vm = 1'b0; v0_mask = '0; exec_result = '0; old_vd = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_wb_valid", VLEN'(wb_valid), '0);
    check("rst_in_ready", VLEN'(in_ready), VLEN'(1));
    check("rst_wb_addr", VLEN'(wb_addr), '0);
    check("rst_wb_data", wb_data, '0);
    check("rst_wb_byte_en", VLEN'(wb_byte_en), '0);
    check("rst_pending", VLEN'(pending_vd), '0);
    check("rst_overflow", VLEN'(overflow_err), '0);

    // Unmasked, sew=32, vl=4 -> bytes 0..15; latency of one edge, no bypass
    wb_ready = 1'b1;
    issue("unmasked", 5'd5, 2'b10, VLW'(4), 1'b1, '0, AA, X55, 64'h0000_0000_0000_FFFF, 1'b1);
    check("lat_wb_valid", VLEN'(wb_valid), VLEN'(1));
    check("lat_pending", VLEN'(pending_vd), VLEN'(32'h0000_0020));
    step();
    check("drained_wb_valid", VLEN'(wb_valid), '0);

    // Masked sew=8, vl=8; mask bits above vl are set but lie in the tail
    issue("masked", 5'd9, 2'b00, VLW'(8), 1'b0, 64'hFFFF_FFFF_FFFF_FFA5, DB, OL, 64'h0000_0000_0000_00A5, 1'b1);
    step();

    // Edge cases back to back: vl=0, sew=11, vl clamp (200 truncates to 72, still > 32)
    issue("vl0", 5'd1, 2'b10, VLW'(0), 1'b1, '1, AA, OL, 64'h0, 1'b1);
    issue("sew_ill", 5'd2, 2'b11, VLW'(8), 1'b1, '1, DB, X55, 64'h0, 1'b1);
    issue("vl_clamp", 5'd3, 2'b01, VLW'(200), 1'b1, '0, DB, X55, '1, 1'b1);
    step(); step();
    check("edge_pending", VLEN'(pending_vd), '0);
    check("edge_overflow", VLEN'(overflow_err), '0);

    // Backpressure: three back-to-back, third rejected
    wb_ready = 1'b0;
    issue("bp_a", 5'd1, 2'b00, VLW'(64), 1'b1, '0, AA, X55, '1, 1'b1);
    issue("bp_b", 5'd2, 2'b10, VLW'(1), 1'b1, '0, DB, OL, 64'h0000_0000_0000_000F, 1'b1);
    issue("bp_c", 5'd4, 2'b00, VLW'(64), 1'b1, '0, OL, X55, '1, 1'b0);
    check("bp_in_ready", VLEN'(in_ready), '0);
    check("bp_overflow", VLEN'(overflow_err), VLEN'(1));
    check("bp_pending", VLEN'(pending_vd), VLEN'(32'h0000_0006));
    step(); step(); step();
    check("bp_hold_valid", VLEN'(wb_valid), VLEN'(1));
    check("bp_hold_addr", VLEN'(wb_addr), VLEN'(1));
    check("bp_hold_data", wb_data, AA);
    check("bp_hold_be", VLEN'(wb_byte_en), VLEN'({NB{1'b1}}));
    wb_ready = 1'b1;
    step(); step();
    check("bp_drained", VLEN'(wb_valid), '0);
    check("bp_overflow_sticky", VLEN'(overflow_err), VLEN'(1));

    // Hazard tracking with a duplicate destination
    wb_ready = 1'b0;
    issue("hz_3a", 5'd3, 2'b10, VLW'(16), 1'b1, '0, AA, OL, '1, 1'b1);
    issue("hz_3b", 5'd3, 2'b10, VLW'(2), 1'b1, '0, DB, OL, 64'h0000_0000_0000_00FF, 1'b1);
    check("hz_pend_33", VLEN'(pending_vd), VLEN'(32'h0000_0008));
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check("hz_pend_3", VLEN'(pending_vd), VLEN'(32'h0000_0008));
    issue("hz_7", 5'd7, 2'b00, VLW'(4), 1'b1, '0, AA, X55, 64'h0000_0000_0000_000F, 1'b1);
    check("hz_pend_37", VLEN'(pending_vd), VLEN'(32'h0000_0088));
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check("hz_pend_7", VLEN'(pending_vd), VLEN'(32'h0000_0080));
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check("hz_pend_none", VLEN'(pending_vd), '0);

    // Reset mid-drain discards the queued entry
    issue("rst_mid", 5'd10, 2'b00, VLW'(8), 1'b1, '0, AA, X55, 64'h0000_0000_0000_00FF, 1'b1);
    check("rst_mid_valid_before", VLEN'(wb_valid), VLEN'(1));
    reset = 1'b1;
    step();
    exp_q.delete();
    check("rst_mid_wb_valid", VLEN'(wb_valid), '0);
    check("rst_mid_pending", VLEN'(pending_vd), '0);
    check("rst_mid_in_ready", VLEN'(in_ready), VLEN'(1));
    check("rst_mid_overflow", VLEN'(overflow_err), '0);
    check("rst_mid_wb_data", wb_data, '0);
    reset = 1'b0;
    wb_ready = 1'b1;
    step(); step();
    check("post_rst_wb_valid", VLEN'(wb_valid), '0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("scoreboard_empty", VLEN'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
